// File: rtl/fir_coef_loader_if.sv
// -----------------------------------------------------------------------------
// fir_coef_loader_if
// Coefficient stream into the FIR coefficient loader.
//
// Handshake: a word transfers on a rising edge where i_coef_valid and
// o_coef_ready are both high. The loader decides o_coef_ready without looking
// at i_coef_valid. The source may assert i_coef_valid at any time and may
// change iv_coef freely while no transfer is happening.
//
// Signals:
//   iv_coef       source -> loader  signed coefficient word
//   i_coef_valid  source -> loader  iv_coef is valid this cycle
//   o_coef_ready  loader -> source  loader accepts iv_coef this cycle
// Modports: master = coefficient source, slave = loader.
// -----------------------------------------------------------------------------
interface fir_coef_loader_if #(
  parameter int DATA_WIDTH = 24
) ();
  logic signed [DATA_WIDTH-1:0] iv_coef;
  logic                         i_coef_valid;
  logic                         o_coef_ready;

  modport master (output iv_coef, output i_coef_valid, input o_coef_ready);
  modport slave  (input iv_coef, input i_coef_valid, output o_coef_ready);
endinterface

// File: rtl/fir_coef_loader.sv
// -----------------------------------------------------------------------------
// fir_coef_loader
// Double-buffered coefficient loader for a NUM_TAPS FIR filter. Words stream
// into a shadow bank. The whole shadow bank is copied into the active bank in
// one edge, and only when the filter sample strobe is high, so the filter
// never sees a mix of old and new coefficients.
//
// Ports:
//   i_clk         clock, rising edge
//   i_rst         synchronous, active-high reset
//   i_load_start  one-cycle pulse that opens (or restarts) a load session
//   coef_if       coefficient stream (slave modport)
//   i_sample_en   filter sample strobe; the only commit point
//   ov_weights    active bank, tap k at [k*DATA_WIDTH +: DATA_WIDTH]
//   o_busy        session in progress (LOAD or WAIT_COMMIT)
//   o_done        one-cycle pulse, high in the first cycle that shows the new bank
//   o_err         sticky: a session was aborted or restarted; cleared by o_done
//   o_dbg_state   current FSM state (0 IDLE, 1 LOAD, 2 WAIT_COMMIT)
// -----------------------------------------------------------------------------
module fir_coef_loader #(
  parameter int DATA_WIDTH = 24,
  parameter int NUM_TAPS   = 16
) (
  input  logic                           i_clk,
  input  logic                           i_rst,
  input  logic                           i_load_start,
  fir_coef_loader_if.slave               coef_if,
  input  logic                           i_sample_en,
  output logic [NUM_TAPS*DATA_WIDTH-1:0] ov_weights,
  output logic                           o_busy,
  output logic                           o_done,
  output logic                           o_err,
  output logic [1:0]                     o_dbg_state
);

  localparam int IDX_W = $clog2(NUM_TAPS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_TAPS - 1);
  // Largest positive Q1.(DATA_WIDTH-1) value: near-unity passthrough on tap 0.
  localparam logic [DATA_WIDTH-1:0] RESET_TAP0 = {1'b0, {(DATA_WIDTH-1){1'b1}}};

  typedef enum logic [1:0] {
    S_IDLE        = 2'd0,
    S_LOAD        = 2'd1,
    S_WAIT_COMMIT = 2'd2
  } state_t;

  state_t                  state_q, state_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic                    ready_q, ready_d;
  logic                    done_q, done_d;
  logic                    err_q, err_d;
  logic                    shadow_we;
  logic                    commit;
  logic                    xfer;

  logic [DATA_WIDTH-1:0]   shadow_q [NUM_TAPS];
  logic [DATA_WIDTH-1:0]   active_q [NUM_TAPS];

  // o_coef_ready is only high in LOAD, so a transfer implies LOAD.
  assign xfer = coef_if.i_coef_valid & ready_q;

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    err_d     = err_q;
    shadow_we = 1'b0;
    commit    = 1'b0;

    // The flag clears in the cycle after the o_done pulse. A new abort in that
    // same cycle still sets it, because the case below overrides this.
    if (done_q) err_d = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (i_load_start) begin
          state_d = S_LOAD;
          idx_d   = '0;
        end
      end
      S_LOAD: begin
        // A restart wins over any transfer in the same cycle, including the
        // final one, so the transfer is dropped.
        if (i_load_start) begin
          state_d = S_LOAD;
          idx_d   = '0;
          err_d   = 1'b1;
        end else if (xfer) begin
          shadow_we = 1'b1;
          if (idx_q == LAST_IDX) state_d = S_WAIT_COMMIT;
          else                   idx_d   = idx_q + 1'b1;
        end
      end
      S_WAIT_COMMIT: begin
        // A commit completes even when a new session starts in the same
        // cycle. That case is not an abort, so o_err is left alone.
        if (i_sample_en) begin
          commit  = 1'b1;
          idx_d   = '0;
          state_d = i_load_start ? S_LOAD : S_IDLE;
        end else if (i_load_start) begin
          state_d = S_LOAD;
          idx_d   = '0;
          err_d   = 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
        idx_d   = '0;
      end
    endcase

    ready_d = (state_d == S_LOAD);
    done_d  = commit;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      ready_q <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      ready_q <= ready_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int k = 0; k < NUM_TAPS; k++) begin
        shadow_q[k] <= '0;
        active_q[k] <= (k == 0) ? RESET_TAP0 : '0;
      end
    end else begin
      if (shadow_we) shadow_q[idx_q] <= coef_if.iv_coef;
      if (commit) begin
        for (int k = 0; k < NUM_TAPS; k++) active_q[k] <= shadow_q[k];
      end
    end
  end

  for (genvar g = 0; g < NUM_TAPS; g++) begin : g_wout
    assign ov_weights[g*DATA_WIDTH +: DATA_WIDTH] = active_q[g];
  end

  assign coef_if.o_coef_ready = ready_q;
  assign o_busy      = (state_q != S_IDLE);
  assign o_done      = done_q;
  assign o_err       = err_q;
  assign o_dbg_state = state_q;

endmodule

// File: tb/tb_fir_coef_loader.sv
// -----------------------------------------------------------------------------
// tb_fir_coef_loader
// Directed bench for fir_coef_loader at the default 24-bit x 16-tap size.
// Inputs are driven 1 time unit after each rising edge. Outputs are sampled at
// the same point, which is after the edge has settled.
// -----------------------------------------------------------------------------
module tb_fir_coef_loader;
  localparam int DW = 24;
  localparam int NT = 16;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic               load_start = 1'b0;
  logic               sample_en  = 1'b0;
  logic [NT*DW-1:0]   weights;
  logic               busy, done, err;
  logic [1:0]         dbg_state;

  fir_coef_loader_if #(.DATA_WIDTH(DW)) cif ();

  fir_coef_loader #(.DATA_WIDTH(DW), .NUM_TAPS(NT)) dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_load_start (load_start),
    .coef_if      (cif.slave),
    .i_sample_en  (sample_en),
    .ov_weights   (weights),
    .o_busy       (busy),
    .o_done       (done),
    .o_err        (err),
    .o_dbg_state  (dbg_state)
  );

  int n_vec = 0;
  int n_err = 0;
  logic [DW-1:0] exp_w [NT];

  // ---------------- helpers ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_vec++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
    end
  endtask

  function automatic logic [DW-1:0] tap_of(input int k);
    return weights[k*DW +: DW];
  endfunction

  task automatic chk_bank(input string tag);
    for (int k = 0; k < NT; k++)
      chk($sformatf("%s_tap%0d", tag, k), 32'(tap_of(k)), 32'(exp_w[k]));
  endtask

  task automatic set_reset_bank();
    for (int k = 0; k < NT; k++) exp_w[k] = (k == 0) ? 24'h7FFFFF : 24'h0;
  endtask

  // ---------------- driver tasks ----------------
  task automatic pulse_load();
    load_start = 1'b1;
    step();
    load_start = 1'b0;
  endtask

  task automatic send_word(input logic [DW-1:0] w);
    cif.iv_coef      = w;
    cif.i_coef_valid = 1'b1;
    step();
    cif.i_coef_valid = 1'b0;
  endtask

  task automatic commit_now();
    sample_en = 1'b1;
    step();
    sample_en = 1'b0;
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    cif.iv_coef      = '0;
    cif.i_coef_valid = 1'b0;

    // Reset state.
    step(); step();
    rst = 1'b0;
    set_reset_bank();
    chk_bank("reset");
    chk("reset_ready", 32'(cif.o_coef_ready), 32'd0);
    chk("reset_busy",  32'(busy), 32'd0);
    chk("reset_done",  32'(done), 32'd0);
    chk("reset_err",   32'(err),  32'd0);
    chk("reset_state", 32'(dbg_state), 32'd0);

    // Stream 16 words back-to-back. The commit happens later, on the sample strobe.
    pulse_load();
    chk("load_busy", 32'(busy), 32'd1);
    for (int k = 0; k < NT; k++) begin
      chk($sformatf("b2b_ready%0d", k), 32'(cif.o_coef_ready), 32'd1);
      send_word(DW'(k + 1));
    end
    chk("b2b_ready_drop", 32'(cif.o_coef_ready), 32'd0);
    chk("b2b_state_wait", 32'(dbg_state), 32'd2);
    step(); step();
    chk_bank("b2b_precommit");
    chk("b2b_done_pre", 32'(done), 32'd0);
    commit_now();
    for (int k = 0; k < NT; k++) exp_w[k] = DW'(k + 1);
    chk_bank("b2b_commit");
    chk("b2b_done", 32'(done), 32'd1);
    chk("b2b_busy", 32'(busy), 32'd0);
    step();
    chk("b2b_done_single", 32'(done), 32'd0);

    // Toggle valid on alternate cycles. Tap 3 gets a negative word. The sample
    // strobe fires during LOAD and must have no effect there.
    pulse_load();
    for (int i = 0; i < 2*NT; i++) begin
      if (i % 2 == 0) begin
        sample_en = 1'b1;
        send_word((i/2 == 3) ? 24'h800000 : DW'(24'h20 + i/2));
        sample_en = 1'b0;
      end else begin
        cif.iv_coef = 24'hABCDEF;
        step();
      end
    end
    chk_bank("tog_loadstrobe");
    chk("tog_state_wait", 32'(dbg_state), 32'd2);
    commit_now();
    for (int k = 0; k < NT; k++) exp_w[k] = (k == 3) ? 24'h800000 : DW'(24'h20 + k);
    chk_bank("tog_commit");
    chk("tog_done", 32'(done), 32'd1);
    step();

    // Abort part way through the load, then run a full session.
    pulse_load();
    for (int k = 0; k < 8; k++) send_word(DW'(24'h200 + k));
    pulse_load();
    chk("restart_err", 32'(err), 32'd1);
    chk("restart_ready", 32'(cif.o_coef_ready), 32'd1);
    for (int k = 0; k < NT; k++) send_word(DW'(24'h100000 + k));
    chk("restart_err_wait", 32'(err), 32'd1);
    commit_now();
    for (int k = 0; k < NT; k++) exp_w[k] = DW'(24'h100000 + k);
    chk_bank("restart_commit");
    chk("restart_done", 32'(done), 32'd1);
    step();
    chk("restart_err_clear", 32'(err), 32'd0);
    chk("restart_done_off", 32'(done), 32'd0);

    // Reset while in WAIT_COMMIT with the strobe high: no commit happens.
    pulse_load();
    for (int k = 0; k < NT; k++) send_word(DW'(24'h5A0000 + k));
    rst = 1'b1;
    sample_en = 1'b1;
    step();
    rst = 1'b0;
    sample_en = 1'b0;
    set_reset_bank();
    chk_bank("rstwait");
    chk("rstwait_done", 32'(done), 32'd0);
    chk("rstwait_busy", 32'(busy), 32'd0);
    chk("rstwait_ready", 32'(cif.o_coef_ready), 32'd0);
    step();
    chk("rstwait_done2", 32'(done), 32'd0);
    chk_bank("rstwait_hold");

    // Load start in the same cycle as the commit.
    pulse_load();
    for (int k = 0; k < NT; k++) send_word(DW'(24'h30 + k));
    load_start = 1'b1;
    sample_en  = 1'b1;
    step();
    load_start = 1'b0;
    sample_en  = 1'b0;
    for (int k = 0; k < NT; k++) exp_w[k] = DW'(24'h30 + k);
    chk_bank("coinc_commit");
    chk("coinc_done",  32'(done), 32'd1);
    chk("coinc_err",   32'(err),  32'd0);
    chk("coinc_busy",  32'(busy), 32'd1);
    chk("coinc_ready", 32'(cif.o_coef_ready), 32'd1);

    // Load start in the same cycle as the final transfer: that word is dropped.
    for (int k = 0; k < NT-1; k++) send_word(DW'(24'h40 + k));
    load_start = 1'b1;
    send_word(24'hDEAD00);
    load_start = 1'b0;
    chk("last_restart_err",   32'(err), 32'd1);
    chk("last_restart_state", 32'(dbg_state), 32'd1);
    chk("last_restart_ready", 32'(cif.o_coef_ready), 32'd1);
    for (int k = 0; k < NT; k++) send_word(DW'(24'h60 + k));
    chk_bank("last_restart_hold");
    commit_now();
    for (int k = 0; k < NT; k++) exp_w[k] = DW'(24'h60 + k);
    chk_bank("last_restart_commit");
    chk("last_restart_done", 32'(done), 32'd1);
    step();
    chk("last_restart_err_clear", 32'(err), 32'd0);

    // ---------------- report ----------------
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  // Guard against a hang.
  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/fir_coef_loader.md
FIR_COEF_LOADER -- requirements
Module: fir_coef_loader

Interface
REQ-001 Parameter DATA_WIDTH, default 24, coefficient width, Q1.23 signed at default.
REQ-002 Parameter NUM_TAPS, default 16, number of weights driven; legal range 2..64.
REQ-003 i_clk  input  1  clock; all state on rising edge.
REQ-004 i_rst  input  1  reset, synchronous, active-high.
REQ-005 i_load_start  input  1  one-cycle pulse; opens a coefficient load session.
REQ-006 iv_coef  input  DATA_WIDTH  signed coefficient word.
REQ-007 i_coef_valid  input  1  iv_coef valid this cycle.
REQ-008 o_coef_ready  output  1  loader accepts iv_coef this cycle.
REQ-009 i_sample_en  input  1  filter sample strobe, the same strobe as the taps' i_en; this is the only commit point.
REQ-010 ov_weights  output  NUM_TAPS*DATA_WIDTH  active weight bank, flattened; tap k occupies bits [k*DATA_WIDTH +: DATA_WIDTH].
REQ-011 o_busy  output  1  high in LOAD or WAIT_COMMIT.
REQ-012 o_done  output  1  one-cycle pulse in the cycle after the active bank updates.
REQ-013 o_err  output  1  sticky flag; an aborted or restarted session has occurred.

Function
REQ-014 Storage: shadow bank and active bank, each NUM_TAPS x DATA_WIDTH; ov_weights is driven directly from the active bank registers, with no combinational path from inputs.
REQ-015 States: IDLE, LOAD, WAIT_COMMIT; state register plus tap index counter, width clog2(NUM_TAPS).
REQ-016 IDLE: o_coef_ready=0; i_coef_valid ignored; i_load_start -> LOAD with index=0.
REQ-017 LOAD: o_coef_ready=1 (registered, asserted the cycle after entry); each cycle with i_coef_valid&o_coef_ready writes shadow[index]=iv_coef and increments index.
REQ-018 LOAD: a transfer with index==NUM_TAPS-1 -> WAIT_COMMIT; o_coef_ready=0 from the next cycle; no index wrap occurs.
REQ-019 Word order: first accepted word -> tap 0, last -> tap NUM_TAPS-1.
REQ-020 WAIT_COMMIT: o_coef_ready=0; on i_sample_en the entire shadow bank copies to the active bank in that single edge; state -> IDLE; o_done=1 the following cycle.
REQ-021 Active bank never changes except at a commit edge coinciding with i_sample_en, so the filter never sees a mixed old/new coefficient set.
REQ-022 i_load_start during LOAD or WAIT_COMMIT: current session discarded, index=0, state=LOAD, o_err set; shadow contents are overwritten by the new session.
REQ-023 i_load_start coincident with a commit (WAIT_COMMIT with i_sample_en): the commit completes, o_done pulses, o_err is not set, and the next state is LOAD with index=0.
REQ-024 i_load_start coincident with the final LOAD transfer: the final transfer is discarded, restart per REQ-022.
REQ-025 i_sample_en in IDLE or LOAD: no effect on the active bank.
REQ-026 o_err clears only on reset or on the next o_done.
REQ-027 Coefficients are stored verbatim; no saturation, rounding or sign manipulation.
REQ-028 Latency: accept-to-commit is at least 1 cycle after the last transfer, with the commit itself gated by the next i_sample_en.

Reset
REQ-029 i_rst takes priority over all inputs, including mid-LOAD and mid-commit.
REQ-030 On reset: state=IDLE, index=0, o_coef_ready=0, o_busy=0, o_done=0, o_err=0.
REQ-031 On reset: active tap 0 = 2**(DATA_WIDTH-1)-1 (0x7FFFFF at default), all other taps = 0, giving near-unity passthrough; shadow bank = 0.

Verification
REQ-032 Reset -> ov_weights tap0=0x7FFFFF, taps1..15=0, o_coef_ready=0, o_busy=0.
REQ-033 Pulse load, stream 16 words 0x000001..0x000010 back-to-back, i_sample_en low -> o_coef_ready drops after the 16th, ov_weights unchanged; assert i_sample_en -> tap k = k+1 next cycle, o_done single pulse.
REQ-034 Stream with i_coef_valid toggling 1/0 and a negative word 0x800000 at tap 3 -> tap3=0x800000 after commit; no words lost or duplicated.
REQ-035 Load 8 words, pulse i_load_start, load 16 words 0x100000+k, commit -> tap k=0x100000+k, o_err high until o_done then low.
REQ-036 i_rst asserted in WAIT_COMMIT concurrent with i_sample_en -> no commit, reset values per REQ-031 and REQ-032, o_done stays 0.
REQ-037 i_load_start coincident with the commit edge -> o_done pulses, o_err stays 0, o_busy stays high, o_coef_ready asserted the following cycle.
